vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; successor to the fixed 640×480 h/v counter pair.
- Runs on the 50 MHz system clock and derives the pixel rate with an internal clock-enable divider, so there is no derived clock domain.
- Produces sync, blank and pixel-clock outputs for the DAC adapter, plus scaled framebuffer coordinates and a linear read address for the dual-port video RAM.
- Delays sync and blank by a programmable number of pixels so they line up with the RAM read latency.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_delay_line.sv | 46 ++++
 rtl/vga_timing_gen.sv | 201 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Default 640x480@60 timing constants and sizing helpers shared
//               by the VGA raster timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;

    // Undelayed raster flags, all active-high before polarity is applied
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_sync_t;

    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int calc_aw(input int h_active, input int v_active,
                                   input int scale);
        int depth;
        depth = (h_active / scale) * (v_active / scale);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_delay_line
// Description : Enable-gated shift register aligning sync/blank flags with the
//               video RAM read latency; DEPTH of 0 is a plain wire.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused_ctrl;
            assign w_unused_ctrl = ^{clk, rst, en};
            assign dout          = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else if (en) begin
                    r_stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator with clock-enable
//               pixel divider, scaled framebuffer addressing and delayed sync.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int SCALE    = 2,
    parameter int PIPE     = 2,
    parameter int CW       = 10,
    parameter int AW       = calc_aw(H_ACTIVE, V_ACTIVE, SCALE)
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    output logic          pix_ce,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          active,
    output logic [CW-1:0] fb_x,
    output logic [CW-1:0] fb_y,
    output logic [AW-1:0] fb_addr,
    output logic          line_start,
    output logic          frame_start,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N,
    output logic          VGA_CLK
);

    localparam int c_h_total = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int c_div_w   = $clog2(CLK_DIV);
    localparam int c_sub_w   = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [c_div_w-1:0] c_div_last   = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_half   = c_div_w'(CLK_DIV / 2);
    localparam logic [CW-1:0]      c_h_last     = CW'(c_h_total - 1);
    localparam logic [CW-1:0]      c_v_last     = CW'(c_v_total - 1);
    localparam logic [CW-1:0]      c_h_act      = CW'(H_ACTIVE);
    localparam logic [CW-1:0]      c_v_act      = CW'(V_ACTIVE);
    localparam logic [CW-1:0]      c_v_act_last = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0]      c_hs_start   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0]      c_hs_end     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0]      c_vs_start   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0]      c_vs_end     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_sub_w-1:0] c_sub_last   = c_sub_w'(SCALE - 1);
    localparam logic [AW-1:0]      c_row_step   = AW'(H_ACTIVE / SCALE);

    logic [c_div_w-1:0] r_div_cnt;
    logic [CW-1:0]      r_h;
    logic [CW-1:0]      r_v;
    logic [c_sub_w-1:0] r_x_sub;
    logic [CW-1:0]      r_x_cnt;
    logic [c_sub_w-1:0] r_y_sub;
    logic [CW-1:0]      r_fb_x;
    logic [CW-1:0]      r_fb_y;
    logic [AW-1:0]      r_line_base;
    logic [AW-1:0]      r_fb_addr;
    logic               r_line_start;
    logic               r_frame_start;

    logic               w_pix_ce;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic [CW-1:0]      w_h_nxt;
    logic [CW-1:0]      w_v_nxt;
    logic [c_sub_w-1:0] w_x_sub_nxt;
    logic [CW-1:0]      w_x_nxt;
    logic [c_sub_w-1:0] w_y_sub_nxt;
    logic [CW-1:0]      w_fb_y_nxt;
    logic [AW-1:0]      w_lb_nxt;
    logic               w_act_nxt;
    vga_sync_t          w_raw;
    vga_sync_t          w_dly;

    assign w_pix_ce = (r_div_cnt == c_div_last);
    assign w_h_wrap = (r_h == c_h_last);
    assign w_v_wrap = w_h_wrap && (r_v == c_v_last);

    // Next raster position and incremental framebuffer coordinates
    always_comb begin
        w_h_nxt     = w_h_wrap ? '0 : r_h + 1'b1;
        w_v_nxt     = r_v;
        w_y_sub_nxt = r_y_sub;
        w_fb_y_nxt  = r_fb_y;
        w_lb_nxt    = r_line_base;
        w_x_sub_nxt = '0;
        w_x_nxt     = '0;

        if (w_v_wrap) begin
            w_v_nxt     = '0;
            w_y_sub_nxt = '0;
            w_fb_y_nxt  = '0;
            w_lb_nxt    = '0;
        end else if (w_h_wrap) begin
            w_v_nxt = r_v + 1'b1;
            if (r_y_sub == c_sub_last) begin
                w_y_sub_nxt = '0;
                w_fb_y_nxt  = r_fb_y + 1'b1;
                // The base stays on the last visible row through vertical blanking
                if (r_v < c_v_act_last) begin
                    w_lb_nxt = r_line_base + c_row_step;
                end
            end else begin
                w_y_sub_nxt = r_y_sub + 1'b1;
            end
        end

        if ((w_h_nxt != '0) && (w_h_nxt < c_h_act)) begin
            if (r_x_sub == c_sub_last) begin
                w_x_sub_nxt = '0;
                w_x_nxt     = r_x_cnt + 1'b1;
            end else begin
                w_x_sub_nxt = r_x_sub + 1'b1;
                w_x_nxt     = r_x_cnt;
            end
        end

        w_act_nxt = (w_h_nxt < c_h_act) && (w_v_nxt < c_v_act);
    end

    always_ff @(posedge CLOCK_50) begin
        if (resetn) begin
            r_div_cnt     <= '0;
            r_h           <= '0;
            r_v           <= '0;
            r_x_sub       <= '0;
            r_x_cnt       <= '0;
            r_y_sub       <= '0;
            r_fb_x        <= '0;
            r_fb_y        <= '0;
            r_line_base   <= '0;
            r_fb_addr     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_pix_ce ? '0 : r_div_cnt + 1'b1;
            r_line_start  <= w_pix_ce && w_h_wrap;
            r_frame_start <= w_pix_ce && w_v_wrap;
            if (w_pix_ce) begin
                r_h         <= w_h_nxt;
                r_v         <= w_v_nxt;
                r_x_sub     <= w_x_sub_nxt;
                r_x_cnt     <= w_x_nxt;
                r_y_sub     <= w_y_sub_nxt;
                r_fb_y      <= w_fb_y_nxt;
                r_line_base <= w_lb_nxt;
                r_fb_x      <= w_act_nxt ? w_x_nxt : '0;
                r_fb_addr   <= w_act_nxt ? (w_lb_nxt + AW'(w_x_nxt)) : w_lb_nxt;
            end
        end
    end

    assign w_raw.hs      = (r_h >= c_hs_start) && (r_h < c_hs_end);
    assign w_raw.vs      = (r_v >= c_vs_start) && (r_v < c_vs_end);
    assign w_raw.blank_n = (r_h < c_h_act) && (r_v < c_v_act);

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE),
        .RST_VAL (3'b000)
    ) u_sync_dly (
        .clk  (CLOCK_50),
        .rst  (resetn),
        .en   (w_pix_ce),
        .din  (w_raw),
        .dout (w_dly)
    );

    assign pix_ce      = w_pix_ce;
    assign h_count     = r_h;
    assign v_count     = r_v;
    assign active      = w_raw.blank_n;
    assign fb_x        = r_fb_x;
    assign fb_y        = r_fb_y;
    assign fb_addr     = r_fb_addr;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign VGA_HS      = w_dly.hs ^ ~HS_POL;
    assign VGA_VS      = w_dly.vs ^ ~VS_POL;
    assign VGA_BLANK_N = w_dly.blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = (r_div_cnt >= c_div_half);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen on a reduced raster, with
//               a divide-by-2 scaled instance and a divide-by-4 unscaled one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VSY = 2, VB = 1;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int CW = 10;
    localparam int A_DIV = 2, A_SC = 2, A_PIPE = 2, A_AW = 5;
    localparam int B_DIV = 4, B_SC = 1, B_PIPE = 0, B_AW = 7;
    localparam int A_FRAME = HT * VT * A_DIV;
    localparam int B_FRAME = HT * VT * B_DIV;

    typedef struct {
        int pix_ce; int vclk; int h; int v; int act; int fb_x; int fb_y;
        int fb_addr; int ls; int fs; int hs; int vs; int bn;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic a_pix_ce, a_act, a_ls, a_fs, a_hs, a_vs, a_bn, a_sync_n, a_vclk;
    logic [CW-1:0] a_h, a_v, a_fbx, a_fby;
    logic [A_AW-1:0] a_addr;
    logic b_pix_ce, b_act, b_ls, b_fs, b_hs, b_vs, b_bn, b_sync_n, b_vclk;
    logic [CW-1:0] b_h, b_v, b_fbx, b_fby;
    logic [B_AW-1:0] b_addr;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(A_DIV), .SCALE(A_SC),
        .PIPE(A_PIPE), .CW(CW), .AW(A_AW)
    ) dut_a (
        .CLOCK_50(clk), .resetn(rst), .pix_ce(a_pix_ce), .h_count(a_h),
        .v_count(a_v), .active(a_act), .fb_x(a_fbx), .fb_y(a_fby),
        .fb_addr(a_addr), .line_start(a_ls), .frame_start(a_fs),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bn),
        .VGA_SYNC_N(a_sync_n), .VGA_CLK(a_vclk)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(B_DIV), .SCALE(B_SC),
        .PIPE(B_PIPE), .CW(CW), .AW(B_AW)
    ) dut_b (
        .CLOCK_50(clk), .resetn(rst), .pix_ce(b_pix_ce), .h_count(b_h),
        .v_count(b_v), .active(b_act), .fb_x(b_fbx), .fb_y(b_fby),
        .fb_addr(b_addr), .line_start(b_ls), .frame_start(b_fs),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn),
        .VGA_SYNC_N(b_sync_n), .VGA_CLK(b_vclk)
    );

    int k;
    int n_tests;
    int n_fail;
    exp_t q_a[$];
    exp_t q_b[$];

    // Expected outputs derived from the clock count since reset release
    function automatic exp_t model(input int kk, input int d, input int s,
                                   input int pp, input int hpol, input int vpol);
        exp_t e;
        int p, h, v, q, hq, vq, lb, rhs, rvs, rbn;
        p = kk / d;
        h = p % HT;
        v = (p / HT) % VT;
        e.pix_ce = (kk % d == d - 1) ? 1 : 0;
        e.vclk   = (kk % d >= d / 2) ? 1 : 0;
        e.h      = h;
        e.v      = v;
        e.act    = (h < HA && v < VA) ? 1 : 0;
        lb       = (((v < VA) ? v : VA - 1) / s) * (HA / s);
        e.fb_x   = (e.act == 1) ? h / s : 0;
        e.fb_addr = (e.act == 1) ? lb + h / s : lb;
        e.fb_y   = v / s;
        e.ls     = (kk % d == 0 && p > 0 && h == 0) ? 1 : 0;
        e.fs     = (e.ls == 1 && v == 0) ? 1 : 0;
        rhs = 0; rvs = 0; rbn = 0;
        if (p >= pp) begin
            q   = p - pp;
            hq  = q % HT;
            vq  = (q / HT) % VT;
            rhs = (hq >= HA + HF && hq < HA + HF + HSY) ? 1 : 0;
            rvs = (vq >= VA + VF && vq < VA + VF + VSY) ? 1 : 0;
            rbn = (hq < HA && vq < VA) ? 1 : 0;
        end
        e.hs = rhs ^ (1 - hpol);
        e.vs = rvs ^ (1 - vpol);
        e.bn = rbn;
        return e;
    endfunction

    task automatic clk_step();
        @(posedge clk);
        #1;
        if (rst) k = 0;
        else     k = k + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) clk_step();
        n_tests++; if (a_h !== '0 || a_v !== '0) begin n_fail++;
            $display("FAIL reset_a_counts: got h=%0d v=%0d expected 0 0", a_h, a_v); end
        n_tests++; if (a_fbx !== '0 || a_fby !== '0 || a_addr !== '0) begin n_fail++;
            $display("FAIL reset_a_fb: got x=%0d y=%0d addr=%0d expected 0 0 0", a_fbx, a_fby, a_addr); end
        n_tests++; if ({a_pix_ce, a_vclk, a_ls, a_fs} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_a_pulses: got %b expected 0000", {a_pix_ce, a_vclk, a_ls, a_fs}); end
        n_tests++; if ({a_hs, a_vs, a_bn, a_sync_n} !== 4'b1100) begin n_fail++;
            $display("FAIL reset_a_sync: got %b expected 1100", {a_hs, a_vs, a_bn, a_sync_n}); end
        n_tests++; if ({b_hs, b_vs, b_sync_n, b_pix_ce} !== 4'b0100) begin n_fail++;
            $display("FAIL reset_b_sync: got %b expected 0100", {b_hs, b_vs, b_sync_n, b_pix_ce}); end
        n_tests++; if (b_h !== '0 || b_v !== '0 || b_addr !== '0) begin n_fail++;
            $display("FAIL reset_b_counts: got h=%0d v=%0d addr=%0d expected 0", b_h, b_v, b_addr); end
        rst = 1'b0;
    endtask

    task automatic test_startup();
        for (int c = 0; c < 8; c++) begin
            n_tests++; if (a_pix_ce !== ((k % A_DIV) == A_DIV - 1)) begin n_fail++;
                $display("FAIL startup_a_pix_ce k=%0d: got %b", k, a_pix_ce); end
            n_tests++; if (b_pix_ce !== ((k % B_DIV) == B_DIV - 1)) begin n_fail++;
                $display("FAIL startup_b_pix_ce k=%0d: got %b", k, b_pix_ce); end
            n_tests++; if (a_h !== CW'(k / A_DIV)) begin n_fail++;
                $display("FAIL startup_a_h k=%0d: got %0d expected %0d", k, a_h, k / A_DIV); end
            clk_step();
        end
    endtask

    task automatic test_frame();
        exp_t e;
        int fs_k[$];
        int bn_cnt, hs_cnt, vs_cnt, ls_cnt;
        bn_cnt = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0;
        for (int c = 0; c < 2 * A_FRAME + 40; c++) begin
            q_a.push_back(model(k + 1, A_DIV, A_SC, A_PIPE, 0, 0));
            clk_step();
            e = q_a.pop_front();
            n_tests++; if (a_pix_ce !== 1'(e.pix_ce) || a_vclk !== 1'(e.vclk)) begin n_fail++;
                $display("FAIL a_ce_clk k=%0d: got %b%b expected %0d%0d", k, a_pix_ce, a_vclk, e.pix_ce, e.vclk); end
            n_tests++; if (a_h !== CW'(e.h) || a_v !== CW'(e.v)) begin n_fail++;
                $display("FAIL a_hv k=%0d: got %0d,%0d expected %0d,%0d", k, a_h, a_v, e.h, e.v); end
            n_tests++; if (a_act !== 1'(e.act)) begin n_fail++;
                $display("FAIL a_active k=%0d: got %b expected %0d", k, a_act, e.act); end
            n_tests++; if (a_fbx !== CW'(e.fb_x) || a_fby !== CW'(e.fb_y)) begin n_fail++;
                $display("FAIL a_fbxy k=%0d: got %0d,%0d expected %0d,%0d", k, a_fbx, a_fby, e.fb_x, e.fb_y); end
            n_tests++; if (a_addr !== A_AW'(e.fb_addr)) begin n_fail++;
                $display("FAIL a_fb_addr k=%0d: got %0d expected %0d", k, a_addr, e.fb_addr); end
            n_tests++; if (a_ls !== 1'(e.ls) || a_fs !== 1'(e.fs)) begin n_fail++;
                $display("FAIL a_starts k=%0d: got %b%b expected %0d%0d", k, a_ls, a_fs, e.ls, e.fs); end
            n_tests++; if (a_hs !== 1'(e.hs) || a_vs !== 1'(e.vs) || a_bn !== 1'(e.bn)) begin n_fail++;
                $display("FAIL a_sync k=%0d: got %b%b%b expected %0d%0d%0d", k, a_hs, a_vs, a_bn, e.hs, e.vs, e.bn); end
            if (e.h == 2 && e.v == 0) begin
                n_tests++; if (a_addr !== A_AW'(1)) begin n_fail++;
                    $display("FAIL addr_h2_v0: got %0d expected 1", a_addr); end
            end
            if (e.h == 0 && e.v == 2) begin
                n_tests++; if (a_addr !== A_AW'(HA / A_SC)) begin n_fail++;
                    $display("FAIL addr_h0_v2: got %0d expected %0d", a_addr, HA / A_SC); end
            end
            if (e.h == HA - 1 && e.v == VA - 1) begin
                n_tests++; if (a_addr !== A_AW'((HA / A_SC) * (VA / A_SC) - 1)) begin n_fail++;
                    $display("FAIL addr_last: got %0d expected %0d", a_addr, (HA / A_SC) * (VA / A_SC) - 1); end
            end
            if (e.h == 20 && e.v == 3) begin
                n_tests++; if (a_addr !== A_AW'(HA / A_SC)) begin n_fail++;
                    $display("FAIL addr_hblank: got %0d expected %0d", a_addr, HA / A_SC); end
            end
            if (a_fs === 1'b1) fs_k.push_back(k);
            if (fs_k.size() == 1) begin
                if (a_ls === 1'b1) ls_cnt++;
                if (a_pix_ce === 1'b1) begin
                    if (a_bn === 1'b1) bn_cnt++;
                    if (a_hs === 1'b0) hs_cnt++;
                    if (a_vs === 1'b0) vs_cnt++;
                end
            end
        end
        n_tests++;
        if (fs_k.size() < 2) begin n_fail++;
            $display("FAIL frame_start_count: got %0d expected at least 2", fs_k.size());
        end else if (fs_k[1] - fs_k[0] != A_FRAME) begin n_fail++;
            $display("FAIL frame_period: got %0d expected %0d", fs_k[1] - fs_k[0], A_FRAME);
        end
        n_tests++; if (bn_cnt != HA * VA) begin n_fail++;
            $display("FAIL blank_pixels: got %0d expected %0d", bn_cnt, HA * VA); end
        n_tests++; if (hs_cnt != HSY * VT) begin n_fail++;
            $display("FAIL hsync_pixels: got %0d expected %0d", hs_cnt, HSY * VT); end
        n_tests++; if (vs_cnt != VSY * HT) begin n_fail++;
            $display("FAIL vsync_pixels: got %0d expected %0d", vs_cnt, VSY * HT); end
        n_tests++; if (ls_cnt != VT) begin n_fail++;
            $display("FAIL line_starts: got %0d expected %0d", ls_cnt, VT); end
    endtask

    task automatic test_mid_reset();
        localparam int MR_K = (5 * HT + 21) * A_DIV + 1;
        exp_t e;
        for (int c = 0; c < A_FRAME && (k % A_FRAME) != MR_K; c++) clk_step();
        n_tests++; if ((k % A_FRAME) != MR_K || a_hs !== 1'b0) begin n_fail++;
            $display("FAIL mid_reset_setup: got k=%0d hs=%b expected k=%0d hs=0", k % A_FRAME, a_hs, MR_K); end
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        n_tests++; if (a_h !== '0 || a_v !== '0 || a_addr !== '0 || a_fbx !== '0 || a_fby !== '0) begin n_fail++;
            $display("FAIL mid_reset_counts: got h=%0d v=%0d addr=%0d expected 0", a_h, a_v, a_addr); end
        n_tests++; if ({a_pix_ce, a_vclk, a_ls, a_fs, a_hs, a_vs, a_bn} !== 7'b0000110) begin n_fail++;
            $display("FAIL mid_reset_flags: got %b expected 0000110", {a_pix_ce, a_vclk, a_ls, a_fs, a_hs, a_vs, a_bn}); end
        for (int c = 0; c < 3 * HT * A_DIV; c++) begin
            q_a.push_back(model(k + 1, A_DIV, A_SC, A_PIPE, 0, 0));
            clk_step();
            e = q_a.pop_front();
            n_tests++;
            if (a_h !== CW'(e.h) || a_v !== CW'(e.v) || a_hs !== 1'(e.hs) ||
                a_bn !== 1'(e.bn) || a_addr !== A_AW'(e.fb_addr)) begin n_fail++;
                $display("FAIL resume k=%0d: got h=%0d v=%0d hs=%b bn=%b addr=%0d expected %0d %0d %0d %0d %0d",
                         k, a_h, a_v, a_hs, a_bn, a_addr, e.h, e.v, e.hs, e.bn, e.fb_addr);
            end
        end
    endtask

    task automatic test_variant();
        exp_t e;
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        for (int c = 0; c < B_FRAME + 40; c++) begin
            q_b.push_back(model(k + 1, B_DIV, B_SC, B_PIPE, 1, 0));
            clk_step();
            e = q_b.pop_front();
            n_tests++; if (b_pix_ce !== 1'(e.pix_ce) || b_vclk !== 1'(e.vclk)) begin n_fail++;
                $display("FAIL b_ce_clk k=%0d: got %b%b expected %0d%0d", k, b_pix_ce, b_vclk, e.pix_ce, e.vclk); end
            n_tests++; if (b_h !== CW'(e.h) || b_v !== CW'(e.v) || b_act !== 1'(e.act)) begin n_fail++;
                $display("FAIL b_hv k=%0d: got %0d,%0d,%b expected %0d,%0d,%0d", k, b_h, b_v, b_act, e.h, e.v, e.act); end
            n_tests++; if (b_fbx !== CW'(e.fb_x) || b_fby !== CW'(e.fb_y) || b_addr !== B_AW'(e.fb_addr)) begin n_fail++;
                $display("FAIL b_fb k=%0d: got %0d,%0d,%0d expected %0d,%0d,%0d", k, b_fbx, b_fby, b_addr, e.fb_x, e.fb_y, e.fb_addr); end
            n_tests++; if (b_hs !== 1'(e.hs) || b_vs !== 1'(e.vs) || b_bn !== 1'(e.bn)) begin n_fail++;
                $display("FAIL b_sync k=%0d: got %b%b%b expected %0d%0d%0d", k, b_hs, b_vs, b_bn, e.hs, e.vs, e.bn); end
            n_tests++; if (b_ls !== 1'(e.ls) || b_fs !== 1'(e.fs)) begin n_fail++;
                $display("FAIL b_starts k=%0d: got %b%b expected %0d%0d", k, b_ls, b_fs, e.ls, e.fs); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        k = 0;
        n_tests = 0;
        n_fail = 0;
        test_reset();
        test_startup();
        test_frame();
        test_mid_reset();
        test_variant();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
